axi_burst_slave: RTL

- Synthesizable AXI4 slave (responder) for 128-bit INCR bursts, backed by an internal register-file memory.
- Serves the read- and write-burst traffic issued by the ISP-style AXI master through the *_s_inf channels.
- Used as a gate-level-capable replacement for the behavioural DRAM model in block-level benches and in FPGA bring-up.
- Handles one transaction at a time. Read and write never overlap.

---
 rtl/axi_burst_slave.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/axi_burst_slave.sv
// AXI4 INCR-burst responder over a 128-bit register file, one transaction at a time, reads win ties.
// Read: first rvalid RD_LAT+1 cycles after AR, then 1 beat/cycle; outputs held while !rready. bvalid 1 cycle after wlast.
module axi_burst_slave #(
  parameter int DEPTH  = 64,
  parameter int RD_LAT = 2,
  parameter int ID_W   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ID_W-1:0] awid_s_inf,
  input  logic [31:0]     awaddr_s_inf,
  input  logic [2:0]      awsize_s_inf,
  input  logic [1:0]      awburst_s_inf,
  input  logic [7:0]      awlen_s_inf,
  input  logic            awvalid_s_inf,
  output logic            awready_s_inf,
  input  logic [127:0]    wdata_s_inf,
  input  logic            wlast_s_inf,
  input  logic            wvalid_s_inf,
  output logic            wready_s_inf,
  output logic [ID_W-1:0] bid_s_inf,
  output logic [1:0]      bresp_s_inf,
  output logic            bvalid_s_inf,
  input  logic            bready_s_inf,
  input  logic [ID_W-1:0] arid_s_inf,
  input  logic [31:0]     araddr_s_inf,
  input  logic [7:0]      arlen_s_inf,
  input  logic [2:0]      arsize_s_inf,
  input  logic [1:0]      arburst_s_inf,
  input  logic            arvalid_s_inf,
  output logic            arready_s_inf,
  output logic [ID_W-1:0] rid_s_inf,
  output logic [127:0]    rdata_s_inf,
  output logic [1:0]      rresp_s_inf,
  output logic            rlast_s_inf,
  output logic            rvalid_s_inf,
  input  logic            rready_s_inf
);
  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [28:0] DEPTH_W = 29'(DEPTH);
  localparam logic [7:0]  LAT     = 8'(RD_LAT);

  typedef enum logic [2:0] {IDLE, R_WAIT, R_DATA, W_DATA, W_RESP} state_t;
  state_t state, state_nxt;

  logic [127:0] mem [DEPTH];
  // Extra top bit keeps an index that runs past 2^28-1 out of range instead of wrapping to 0.
  logic [28:0]  idx, rd_idx;
  logic [7:0]   beat, len, cnt;
  logic         ready_q, bad_q, err, over;
  logic         ar_hs, aw_hs, r_hs, w_hs, rd_go, rd_adv, rd_oor, wr_oor, wr_en, w_err;
  logic         unused;

  assign unused = ^{awaddr_s_inf[3:0], araddr_s_inf[3:0]};

  assign arready_s_inf = ready_q;
  assign awready_s_inf = ready_q && !arvalid_s_inf;
  assign wready_s_inf  = (state == W_DATA);
  assign bvalid_s_inf  = (state == W_RESP);

  assign ar_hs  = arvalid_s_inf && arready_s_inf;
  assign aw_hs  = awvalid_s_inf && awready_s_inf;
  assign r_hs   = rvalid_s_inf && rready_s_inf;
  assign w_hs   = wvalid_s_inf && wready_s_inf;
  assign rd_go  = (state == R_WAIT) && (cnt == LAT);
  assign rd_adv = r_hs && !rlast_s_inf;
  assign rd_idx = rd_go ? idx : idx + 29'd1;
  assign rd_oor = (rd_idx >= DEPTH_W);
  assign wr_oor = (idx >= DEPTH_W);
  // Beats after the len-th one are dropped until wlast arrives.
  assign wr_en  = w_hs && !over && !wr_oor;
  assign w_err  = over || wr_oor || (wlast_s_inf && (beat != len));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ar_hs)      state_nxt = R_WAIT;
        else if (aw_hs) state_nxt = W_DATA;
      end
      R_WAIT: if (rd_go) state_nxt = R_DATA;
      R_DATA: if (r_hs && rlast_s_inf) state_nxt = IDLE;
      W_DATA: if (w_hs && wlast_s_inf) state_nxt = W_RESP;
      W_RESP: if (bready_s_inf) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt == IDLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx          <= '0;
      beat         <= '0;
      len          <= '0;
      cnt          <= '0;
      bad_q        <= 1'b0;
      err          <= 1'b0;
      over         <= 1'b0;
      rvalid_s_inf <= 1'b0;
      rdata_s_inf  <= '0;
      rresp_s_inf  <= '0;
      rlast_s_inf  <= 1'b0;
      rid_s_inf    <= '0;
      bid_s_inf    <= '0;
      bresp_s_inf  <= '0;
    end else begin
      if (ar_hs) begin
        rid_s_inf <= arid_s_inf;
        idx       <= {1'b0, araddr_s_inf[31:4]};
        len       <= arlen_s_inf;
        beat      <= '0;
        cnt       <= '0;
        bad_q     <= (arsize_s_inf != 3'b100) || (arburst_s_inf != 2'b01);
      end else if (aw_hs) begin
        bid_s_inf <= awid_s_inf;
        idx       <= {1'b0, awaddr_s_inf[31:4]};
        len       <= awlen_s_inf;
        beat      <= '0;
        over      <= 1'b0;
        err       <= (awsize_s_inf != 3'b100) || (awburst_s_inf != 2'b01);
      end
      if (state == R_WAIT) cnt <= cnt + 8'd1;
      if (rd_go || rd_adv) begin
        rvalid_s_inf <= 1'b1;
        rdata_s_inf  <= rd_oor ? '0 : mem[rd_idx[AW-1:0]];
        rresp_s_inf  <= (rd_oor || bad_q) ? 2'b10 : 2'b00;
        rlast_s_inf  <= rd_go ? (len == 8'd0) : (beat + 8'd1 == len);
      end
      if (rd_adv) begin
        idx  <= idx + 29'd1;
        beat <= beat + 8'd1;
      end
      if (r_hs && rlast_s_inf) rvalid_s_inf <= 1'b0;
      if (w_hs) begin
        idx  <= idx + 29'd1;
        beat <= beat + 8'd1;
        if ((beat == len) && !wlast_s_inf) over <= 1'b1;
        if (w_err) err <= 1'b1;
        if (wlast_s_inf) bresp_s_inf <= (err || w_err) ? 2'b10 : 2'b00;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[idx[AW-1:0]] <= wdata_s_inf;
  end
endmodule
